// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle between decode and the execute unit.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_bit;
    logic            funct7_m;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, alu_op, funct3, funct7_bit, funct7_m, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, busy
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7_bit, funct7_m, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute unit with iterative shifter and registered result.
// Defining ALU_EXEC_MUL_EN adds an iterative radix-2 MUL path.
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input logic           clk,
    input logic           rst_n,
    alu_exec_unit_if.slave io
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);
`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_OK = 1'b1;
`else
    localparam bit MUL_OK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
`ifdef ALU_EXEC_MUL_EN
        S_MUL,
`endif
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
    } op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d, dec_op;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d, step;
    logic [XLEN-1:0] result_q, result_d, alu_out, sra_a;
    logic            zero_q, zero_d, illegal_q, illegal_d;
`ifdef ALU_EXEC_MUL_EN
    logic [XLEN-1:0] acc_q, acc_d;
`endif

    always_comb begin
        dec_op = OP_ILL;
        if (!io.alu_op[1])
            dec_op = io.alu_op[0] ? OP_SUB : OP_ADD;
        else if (io.funct7_bit && io.funct3 != 3'b101 && io.funct3 != 3'b000)
            dec_op = OP_ILL;
        else if (io.alu_op == 2'b10 && io.funct7_m)
            dec_op = (MUL_OK && io.funct3 == 3'b000) ? OP_MUL : OP_ILL;
        else
            case (io.funct3)
                3'b000:  dec_op = (!io.alu_op[0] && io.funct7_bit) ? OP_SUB : OP_ADD;
                3'b001:  dec_op = OP_SLL;
                3'b010:  dec_op = OP_SLT;
                3'b011:  dec_op = OP_SLTU;
                3'b100:  dec_op = OP_XOR;
                3'b101:  dec_op = io.funct7_bit ? OP_SRA : OP_SRL;
                3'b110:  dec_op = OP_OR;
                default: dec_op = OP_AND;
            endcase
    end

    // Shift ops have already been applied to a_q by the time they reach the result mux.
    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_ADD:                 alu_out = a_q + b_q;
            OP_SUB:                 alu_out = a_q - b_q;
            OP_SLT:                 alu_out = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU:                alu_out = {{(XLEN-1){1'b0}}, a_q < b_q};
            OP_XOR:                 alu_out = a_q ^ b_q;
            OP_OR:                  alu_out = a_q | b_q;
            OP_AND:                 alu_out = a_q & b_q;
            OP_SLL, OP_SRL, OP_SRA: alu_out = a_q;
            default:                alu_out = '0;
        endcase
    end

    assign step  = (cnt_q < STEP) ? cnt_q : STEP;
    assign sra_a = $signed(a_q) >>> step;

    // S_SHIFT with nothing left to shift doubles as the one-cycle execute slot.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_EXEC_MUL_EN
        acc_d     = acc_q;
`endif
        case (state_q)
            S_IDLE: if (io.in_valid) begin
                op_d    = dec_op;
                a_d     = io.op_a;
                b_d     = io.op_b;
                cnt_d   = (dec_op == OP_SLL || dec_op == OP_SRL || dec_op == OP_SRA) ?
                          {1'b0, io.op_b[SW-1:0]} : '0;
                state_d = S_SHIFT;
`ifdef ALU_EXEC_MUL_EN
                if (dec_op == OP_MUL) begin
                    cnt_d   = CW'(XLEN);
                    acc_d   = '0;
                    state_d = S_MUL;
                end
`endif
            end
            S_SHIFT: if (cnt_q == '0) begin
                result_d  = alu_out;
                zero_d    = alu_out == '0;
                illegal_d = op_q == OP_ILL;
                state_d   = S_DONE;
            end else begin
                a_d   = op_q == OP_SLL ? a_q << step : op_q == OP_SRA ? sra_a : a_q >> step;
                cnt_d = cnt_q - step;
            end
`ifdef ALU_EXEC_MUL_EN
            S_MUL: if (cnt_q == '0) begin
                result_d  = acc_q;
                zero_d    = acc_q == '0;
                illegal_d = 1'b0;
                state_d   = S_DONE;
            end else begin
                acc_d = b_q[0] ? acc_q + a_q : acc_q;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - 1'b1;
            end
`endif
            S_DONE: if (io.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign io.in_ready  = state_q == S_IDLE;
    assign io.busy      = state_q != S_IDLE;
    assign io.out_valid = state_q == S_DONE;
    assign io.result    = result_q;
    assign io.zero      = zero_q;
    assign io.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed checks of alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;

    alu_exec_unit_if #(.XLEN(XLEN)) bus ();
    alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(4)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

    always #5 clk = ~clk;

    // Expected result, illegal flag and out_valid latency (edges after accept).
    function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic f7b, input logic f7m,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = 32'd0;
        ill = 1'b0;
        lat = 1;
        if (op[1] && f7b && f3 != 3'd5 && f3 != 3'd0) ill = 1'b1;
        else if (op == 2'b10 && f7m) begin
            if (MUL_EN && f3 == 3'd0) begin r = a * b; lat = 33; end
            else ill = 1'b1;
        end
        else if (op == 2'b00) r = a + b;
        else if (op == 2'b01) r = a - b;
        else case (f3)
            3'd0: r = (op == 2'b10 && f7b) ? a - b : a + b;
            3'd1: begin r = a << sh; lat = 1 + (sh + 3) / 4; end
            3'd2: r = {31'd0, $signed(a) < $signed(b)};
            3'd3: r = {31'd0, a < b};
            3'd4: r = a ^ b;
            3'd5: begin r = f7b ? 32'($signed(a) >>> sh) : a >> sh; lat = 1 + (sh + 3) / 4; end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic f7b, input logic f7m,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic z, output logic ill);
        bus.alu_op = op; bus.funct3 = f3; bus.funct7_bit = f7b; bus.funct7_m = f7m;
        bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.alu_op = 2'($urandom); bus.funct3 = 3'($urandom);
        bus.funct7_bit = 1'($urandom); bus.funct7_m = 1'($urandom);
        bus.op_a = $urandom; bus.op_b = $urandom;
        lat = 0;
        for (int i = 1; i <= 100 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) lat = i;
        end
        res = bus.result; z = bus.zero; ill = bus.illegal;
    endtask

    task automatic finish_op;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
        total++; if (bus.result !== 32'd0) $display("FAIL reset result got %h exp 0", bus.result); else pass_cnt++;
        total++; if (bus.zero !== 1'b0) $display("FAIL reset zero got %b exp 0", bus.zero); else pass_cnt++;
        total++; if (bus.illegal !== 1'b0) $display("FAIL reset illegal got %b exp 0", bus.illegal); else pass_cnt++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset busy got %b exp 0", bus.busy); else pass_cnt++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_add;
        int lat; logic [31:0] r; logic z, il;
        do_op(2'b00, 3'd2, 1'b0, 1'b0, 32'h5, 32'hFFFFFFFB, lat, r, z, il);
        total++; if (lat != 1) $display("FAIL add latency got %0d exp 1", lat); else pass_cnt++;
        total++; if (r !== 32'h0) $display("FAIL add result got %h exp 00000000", r); else pass_cnt++;
        total++; if (z !== 1'b1) $display("FAIL add zero got %b exp 1", z); else pass_cnt++;
        total++; if (il !== 1'b0) $display("FAIL add illegal got %b exp 0", il); else pass_cnt++;
        finish_op();
    endtask

    task automatic test_branch_backpressure;
        int lat; logic [31:0] r; logic z, il;
        do_op(2'b01, 3'd5, 1'b0, 1'b0, 32'd7, 32'd9, lat, r, z, il);
        total++; if (lat != 1) $display("FAIL beq latency got %0d exp 1", lat); else pass_cnt++;
        total++; if (r !== 32'hFFFFFFFE) $display("FAIL beq result got %h exp FFFFFFFE", r); else pass_cnt++;
        total++; if (z !== 1'b0) $display("FAIL beq zero got %b exp 0", z); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFFFFFE || bus.zero !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
                $display("FAIL hold cycle %0d got v=%b r=%h z=%b busy=%b rdy=%b exp v=1 r=FFFFFFFE z=0 busy=1 rdy=0",
                         i, bus.out_valid, bus.result, bus.zero, bus.busy, bus.in_ready);
            else pass_cnt++;
        end
        finish_op();
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL release got v=%b busy=%b rdy=%b exp v=0 busy=0 rdy=1", bus.out_valid, bus.busy, bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_sra;
        int lat; logic [31:0] r; logic z, il;
        do_op(2'b10, 3'd5, 1'b1, 1'b0, 32'h80000000, 32'd9, lat, r, z, il);
        total++; if (lat != 4) $display("FAIL sra9 latency got %0d exp 4", lat); else pass_cnt++;
        total++; if (r !== 32'hFFC00000) $display("FAIL sra9 result got %h exp FFC00000", r); else pass_cnt++;
        finish_op();
        do_op(2'b10, 3'd5, 1'b1, 1'b0, 32'h80000000, 32'h00000020, lat, r, z, il);
        total++; if (lat != 1) $display("FAIL sra0 latency got %0d exp 1", lat); else pass_cnt++;
        total++; if (r !== 32'h80000000) $display("FAIL sra0 result got %h exp 80000000", r); else pass_cnt++;
        finish_op();
    endtask

    task automatic test_illegal;
        int lat; logic [31:0] r; logic z, il;
        do_op(2'b10, 3'd4, 1'b1, 1'b0, 32'h1234, 32'h5678, lat, r, z, il);
        total++; if (lat != 1) $display("FAIL illegal latency got %0d exp 1", lat); else pass_cnt++;
        total++; if (r !== 32'd0) $display("FAIL illegal result got %h exp 0", r); else pass_cnt++;
        total++; if (il !== 1'b1) $display("FAIL illegal flag got %b exp 1", il); else pass_cnt++;
        finish_op();
    endtask

    task automatic test_mul;
        int lat, el; logic [31:0] r, er; logic z, il, eil;
        model(2'b10, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd3, er, eil, el);
        do_op(2'b10, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd3, lat, r, z, il);
        total++; if (lat != el) $display("FAIL mul latency got %0d exp %0d", lat, el); else pass_cnt++;
        total++; if (r !== er) $display("FAIL mul result got %h exp %h", r, er); else pass_cnt++;
        total++; if (il !== eil) $display("FAIL mul illegal got %b exp %b", il, eil); else pass_cnt++;
        finish_op();
    endtask

    task automatic test_random;
        int lat, el; logic [31:0] r, er, a, b; logic z, il, eil;
        logic [1:0] op; logic [2:0] f3; logic f7b, f7m;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom); f3 = 3'($urandom);
            f7b = ($urandom_range(0, 3) == 0); f7m = ($urandom_range(0, 5) == 0);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 4) == 0) b = a;
            model(op, f3, f7b, f7m, a, b, er, eil, el);
            do_op(op, f3, f7b, f7m, a, b, lat, r, z, il);
            total++;
            if (lat != el || r !== er || z !== (er == 32'd0) || il !== eil)
                $display("FAIL rand%0d op=%b f3=%0d f7b=%b f7m=%b a=%h b=%h got lat=%0d r=%h z=%b il=%b exp lat=%0d r=%h z=%b il=%b",
                         n, op, f3, f7b, f7m, a, b, lat, r, z, il, el, er, er == 32'd0, eil);
            else pass_cnt++;
            finish_op();
        end
    endtask

    task automatic test_back_to_back;
        int lat, el; logic [31:0] r, er, a, b; logic z, il, eil;
        for (int n = 0; n < 4; n++) begin
            total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b%0d in_ready got %b exp 1", n, bus.in_ready); else pass_cnt++;
            a = $urandom; b = $urandom;
            model(2'b11, 3'(n + 4), 1'b0, 1'b0, a, b, er, eil, el);
            do_op(2'b11, 3'(n + 4), 1'b0, 1'b0, a, b, lat, r, z, il);
            total++;
            if (lat != el || r !== er)
                $display("FAIL b2b%0d got lat=%0d r=%h exp lat=%0d r=%h", n, lat, r, el, er);
            else pass_cnt++;
            finish_op();
        end
    endtask

    task automatic test_reset_mid_shift;
        int lat; logic [31:0] r, a, b; logic z, il; bit seen;
        bus.alu_op = 2'b10; bus.funct3 = 3'd1; bus.funct7_bit = 1'b0; bus.funct7_m = 1'b0;
        bus.op_a = $urandom | 32'h1; bus.op_b = 32'd31; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b1) $display("FAIL midrst busy before got %b exp 1", bus.busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.zero !== 1'b0 || bus.illegal !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL midrst outputs got v=%b r=%h z=%b il=%b busy=%b rdy=%b exp v=0 r=0 z=0 il=0 busy=0 rdy=1",
                     bus.out_valid, bus.result, bus.zero, bus.illegal, bus.busy, bus.in_ready);
        else pass_cnt++;
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
        total++; if (seen) $display("FAIL midrst aborted op got out_valid=1 exp 0"); else pass_cnt++;
        a = $urandom; b = $urandom;
        do_op(2'b00, 3'd0, 1'b0, 1'b0, a, b, lat, r, z, il);
        total++;
        if (lat != 1 || r !== a + b || il !== 1'b0)
            $display("FAIL midrst add got lat=%0d r=%h il=%b exp lat=1 r=%h il=0", lat, r, il, a + b);
        else pass_cnt++;
        finish_op();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_op = 2'b00; bus.funct3 = 3'd0;
        bus.funct7_bit = 1'b0; bus.funct7_m = 1'b0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_add();
        test_branch_backpressure();
        test_sra();
        test_illegal();
        test_mul();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised execute unit that replaces the combinational ALU-control decode plus ALU pair. It decodes alu_op/funct3/funct7 into the full RV32I integer op set and executes the op with a valid/ready handshake on input and output. Single-cycle ops use a registered result. Shifts run iteratively and MUL optionally runs iteratively. It sits between the decode stage and writeback/branch logic of the core.

Parameters:
XLEN, 32, datapath width; must be a power of two, at least 8.
SHIFT_STEP, 4, maximum bit positions shifted per cycle; must be a power of two, from 1 to XLEN.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept; high only in IDLE
alu_op  in  2  00 load/store add, 01 branch compare, 10 R-type, 11 I-type ALU
funct3  in  3  instruction funct3
funct7_bit  in  1  instruction bit 30 (SUB/SRA select)
funct7_m  in  1  instruction bit 25 (M-extension select)
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B, or immediate for I-type
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result
zero  out  1  result equals 0
illegal  out  1  decoded combination is unsupported
busy  out  1  state is not IDLE

Behaviour:
- Reset values: state IDLE, out_valid 0, result 0, zero 0, illegal 0, busy 0, in_ready 1.
- Accept: an operation is accepted on the edge where in_valid and in_ready are both high. Operands and the decoded op are captured into registers; later input changes are ignored.
- Decode rules:
  - alu_op 00: ADD.
  - alu_op 01: SUB, regardless of funct3.
  - alu_op 10 or 11, by funct3: 000 ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7_bit=1; 110 OR; 111 AND.
  - alu_op 10, funct3 000, funct7_bit 1: SUB.
  - alu_op 11, funct3 000: ADDI; funct7_bit is ignored.
- Illegal combinations:
  - funct7_bit=1 with any funct3 other than 101, except the R-type 000 case (SUB).
  - funct7_m=1 with alu_op 10, when the MUL path is absent or funct3 is not 000.
  - An illegal op completes as single-cycle with result 0 and illegal=1.
- Arithmetic: results wrap modulo 2^XLEN. SLT compares signed and SLTU compares unsigned; both give result 0 or 1. Shift amount is op_b[log2(XLEN)-1:0]. SRA replicates op_a[XLEN-1].
- State machine:
  - IDLE: on accept, go to SHIFT (shift op with shamt≠0), MUL (MUL op), or DONE (all other ops).
  - SHIFT: each cycle shift by min(SHIFT_STEP, remaining), then decrement remaining. Go to DONE when remaining reaches 0.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, XLEN cycles. Result is the low XLEN bits. Go to DONE after XLEN cycles.
  - DONE: out_valid=1. result, zero and illegal stay stable until out_ready=1. On the out_ready edge, clear out_valid and go to IDLE.
- Latency: define the accept edge as edge N.
  - Single-cycle ops, shamt=0 shifts, and illegal ops: out_valid is high after edge N+1.
  - Shifts: out_valid after edge N+1+ceil(shamt/SHIFT_STEP).
  - MUL: out_valid after edge N+1+XLEN.
- Throughput: in_ready is 0 in DONE, so there is no overlap. The next accept can occur at the earliest on the edge after the DONE handshake.
- zero = (result == 0). It is registered together with result.
- Back-pressure: while out_ready=0 in DONE, all outputs hold indefinitely.
- Reset mid-operation: asynchronous rst_n low aborts SHIFT or MUL immediately. Outputs return to their reset values and no out_valid is produced for the aborted op.

Optional Feature:
Macro ALU_EXEC_MUL_EN.
- Defined: alu_op 10, funct7_m 1, funct3 000 executes MUL via the MUL state.
- Undefined: the MUL state and multiplier datapath are not compiled. Every funct7_m=1 R-type op is illegal (result 0, illegal=1, single-cycle latency).

Test Plan:
- ADD: alu_op 00, op_a 0x00000005, op_b 0xFFFFFFFB, accept at edge N → out_valid after edge N+1, result 0x00000000, zero 1, illegal 0.
- BEQ and back-pressure: alu_op 01, op_a 7, op_b 9, out_ready held 0 for 5 cycles → result 0xFFFFFFFE, zero 0; outputs and out_valid stay stable until out_ready=1; busy drops and in_ready=1 the next cycle.
- SRA with SHIFT_STEP=4: alu_op 10, funct3 101, funct7_bit 1, op_a 0x80000000, op_b 9, accept at edge N → out_valid after edge N+4, result 0xFFC00000. A second case with shamt 0 gives out_valid after edge N+1 and result op_a.
- Illegal: alu_op 10, funct3 100, funct7_bit 1 → after edge N+1, result 0, illegal 1.
- MUL: alu_op 10, funct7_m 1, funct3 000, op_a 0xFFFFFFFF, op_b 3.
  - With ALU_EXEC_MUL_EN defined: out_valid after edge N+33, result 0xFFFFFFFD.
  - Without the macro: illegal 1 after edge N+1.
- Reset mid-shift: SLL, op_b 31; assert rst_n low 3 cycles after accept → outputs return to reset values, no out_valid; after reset release a fresh ADD completes normally.
